// File: rtl/uart_cmd_frame_assembler.sv
// Collects UART bytes into an opcode/address/data command frame and hands it to the
// command decoder over valid/ready; drops stalled partial frames and flags lost bytes.
module uart_cmd_frame_assembler #(
   parameter int OPC_BYTES      = 2,
   parameter int ADDR_BYTES     = 2,
   parameter int DATA_BYTES     = 4,
   parameter int TIMEOUT_CYCLES = 13020
) (
   input  logic                      i_clock,
   input  logic                      i_n_reset,
   input  logic                      i_rx_done,
   input  logic [7:0]                i_rx_data,
   input  logic                      i_cmd_ready,
   output logic                      o_cmd_valid,
   output logic [8*OPC_BYTES-1:0]    o_opcode,
   output logic [8*ADDR_BYTES-1:0]   o_addr,
   output logic [8*DATA_BYTES-1:0]   o_data,
   output logic                      o_busy,
   output logic                      o_overrun,
   output logic                      o_timeout
);

   // Handshake: a frame moves when o_cmd_valid && i_cmd_ready at a rising edge;
   // o_cmd_valid and the fields stay stable until that edge.
   localparam int N  = OPC_BYTES + ADDR_BYTES + DATA_BYTES;
   localparam int CW = $clog2(N + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int TLIM = TIMEOUT_CYCLES - 1;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_HOLD    = 1'b1
   } state_t;

   state_t               r_state;
   logic [CW-1:0]        r_count;
   logic [TW-1:0]        r_tcnt;
   logic [8*(N-1)-1:0]   r_shift;
   logic [8*N-1:0]       w_frame;

   // Earlier bytes sit in the shift register, so the newest byte completes the frame
   // in big-endian arrival order without a per-slot write decoder.
   assign w_frame = {r_shift, i_rx_data};

   always_ff @(posedge i_clock) begin
      if (!i_n_reset) begin
         r_state     <= ST_COLLECT;
         r_count     <= '0;
         r_tcnt      <= '0;
         r_shift     <= '0;
         o_cmd_valid <= 1'b0;
         o_opcode    <= '0;
         o_addr      <= '0;
         o_data      <= '0;
         o_busy      <= 1'b0;
         o_overrun   <= 1'b0;
         o_timeout   <= 1'b0;
      end else begin
         o_overrun <= 1'b0;
         o_timeout <= 1'b0;
         case (r_state)
            ST_COLLECT: begin
               if (i_rx_done) begin
                  r_shift <= {r_shift[8*(N-2)-1:0], i_rx_data};
                  r_tcnt  <= '0;
                  if (r_count == CW'(N - 1)) begin
                     r_state     <= ST_HOLD;
                     r_count     <= CW'(N);
                     o_cmd_valid <= 1'b1;
                     o_busy      <= 1'b0;
                     o_opcode    <= w_frame[8*N-1 -: 8*OPC_BYTES];
                     o_addr      <= w_frame[8*(ADDR_BYTES+DATA_BYTES)-1 -: 8*ADDR_BYTES];
                     o_data      <= w_frame[8*DATA_BYTES-1:0];
                  end else begin
                     r_count <= r_count + CW'(1);
                     o_busy  <= 1'b1;
                  end
               end else if (r_count != '0) begin
                  // Expiry lands exactly TIMEOUT_CYCLES edges after the last accepted byte.
                  if (r_tcnt == TW'(TLIM)) begin
                     r_count   <= '0;
                     r_tcnt    <= '0;
                     o_timeout <= 1'b1;
                     o_busy    <= 1'b0;
                  end else begin
                     r_tcnt <= r_tcnt + TW'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (i_cmd_ready) begin
                  r_state     <= ST_COLLECT;
                  o_cmd_valid <= 1'b0;
                  r_tcnt      <= '0;
                  if (i_rx_done) begin
                     r_shift <= {r_shift[8*(N-2)-1:0], i_rx_data};
                     r_count <= CW'(1);
                     o_busy  <= 1'b1;
                  end else begin
                     r_count <= '0;
                  end
               end else if (i_rx_done) begin
                  o_overrun <= 1'b1;
               end
            end
            default: r_state <= ST_COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_frame_assembler.sv
// Directed bench for uart_cmd_frame_assembler: table-driven frames plus hand-written
// sequences for hold/overrun, timeout, same-cycle transfer, mid-frame reset and streaming.
module tb_uart_cmd_frame_assembler;

   localparam int T   = 40;
   localparam int GAP = 5;

   logic        clk;
   logic        n_reset;
   logic        rx_done;
   logic [7:0]  rx_data;
   logic        cmd_ready;
   logic        cmd_valid;
   logic [15:0] opcode;
   logic [15:0] addr;
   logic [31:0] data;
   logic        busy;
   logic        overrun;
   logic        timeout;

   int n_checks = 0;
   int n_pass   = 0;
   int n_ovr    = 0;
   int n_tmo    = 0;
   int n_xfer   = 0;
   bit stream_mon = 1'b0;
   logic [63:0] exp_q[$];

   typedef struct {
      logic [63:0] bytes;
      logic [15:0] op;
      logic [15:0] ad;
      logic [31:0] dt;
   } vec_t;
   vec_t vecs[3];

   uart_cmd_frame_assembler #(
      .OPC_BYTES(2), .ADDR_BYTES(2), .DATA_BYTES(4), .TIMEOUT_CYCLES(T)
   ) dut (
      .i_clock(clk), .i_n_reset(n_reset), .i_rx_done(rx_done), .i_rx_data(rx_data),
      .i_cmd_ready(cmd_ready), .o_cmd_valid(cmd_valid), .o_opcode(opcode),
      .o_addr(addr), .o_data(data), .o_busy(busy), .o_overrun(overrun),
      .o_timeout(timeout)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // pulse counters and stream scoreboard, sampled away from the active edge
   always @(negedge clk) begin
      if (overrun) n_ovr++;
      if (timeout) n_tmo++;
      if (stream_mon && cmd_valid && cmd_ready) begin
         n_xfer++;
         if (exp_q.size() == 0) check("stream_extra_frame", 64'd1, 64'd0);
         else check("stream_frame", {opcode, addr, data}, exp_q.pop_front());
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1 rx_done = 1'b1; rx_data = b;
      @(posedge clk);
      #1 rx_done = 1'b0;
   endtask

   task automatic send_frame(input logic [63:0] f, input int gap);
      for (int i = 0; i < 8; i++) begin
         send_byte(f[63-8*i -: 8]);
         if (i < 7) idle(gap);
      end
   endtask

   task automatic check_frame(input string tag, input logic [15:0] op,
                              input logic [15:0] ad, input logic [31:0] dt);
      check({tag, "_valid"}, cmd_valid, 1);
      check({tag, "_opcode"}, opcode, op);
      check({tag, "_addr"}, addr, ad);
      check({tag, "_data"}, data, dt);
   endtask

   initial begin
      vecs[0] = '{64'h0102A000DEADBEEF, 16'h0102, 16'hA000, 32'hDEADBEEF};
      vecs[1] = '{64'h1112131415161718, 16'h1112, 16'h1314, 32'h15161718};
      vecs[2] = '{64'hFF00807F01FE5AA5, 16'hFF00, 16'h807F, 32'h01FE5AA5};

      n_reset = 1'b0; rx_done = 1'b0; rx_data = 8'h00; cmd_ready = 1'b1;
      idle(3);
      check("rst_valid", cmd_valid, 0);
      check("rst_fields", {opcode, addr, data}, 64'd0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_timeout", timeout, 0);
      n_reset = 1'b1;
      idle(2);

      // table-driven frames, consumer always ready
      for (int v = 0; v < 3; v++) begin
         send_frame(vecs[v].bytes, GAP);
         check_frame("tbl", vecs[v].op, vecs[v].ad, vecs[v].dt);
         check("tbl_busy_done", busy, 0);
         idle(1);
         check("tbl_valid_low", cmd_valid, 0);
         idle(4);
      end

      // hold with a stray byte: overrun, stable fields, stray byte discarded
      cmd_ready = 1'b0;
      send_frame(64'h0102A000DEADBEEF, GAP);
      check_frame("hold", 16'h0102, 16'hA000, 32'hDEADBEEF);
      idle(50);
      send_byte(8'h55);
      check("hold_overrun_pulse", overrun, 1);
      check_frame("hold_stable", 16'h0102, 16'hA000, 32'hDEADBEEF);
      idle(1);
      check("hold_overrun_end", overrun, 0);
      idle(20);
      check("hold_still_valid", cmd_valid, 1);
      cmd_ready = 1'b1;
      idle(1);
      check("hold_released", cmd_valid, 0);
      check("hold_busy", busy, 0);
      send_frame(64'h1112131415161718, GAP);
      check_frame("after_hold", 16'h1112, 16'h1314, 32'h15161718);
      idle(3);

      // timeout after 3 bytes
      send_byte(8'hAA); idle(GAP);
      send_byte(8'hBB); idle(GAP);
      send_byte(8'hCC);
      check("tmo_busy", busy, 1);
      idle(T - 1);
      check("tmo_not_yet", timeout, 0);
      check("tmo_busy_still", busy, 1);
      idle(1);
      check("tmo_pulse", timeout, 1);
      check("tmo_busy_fell", busy, 0);
      idle(1);
      check("tmo_pulse_end", timeout, 0);
      idle(3);
      send_frame(64'h1112131415161718, GAP);
      check_frame("after_tmo", 16'h1112, 16'h1314, 32'h15161718);
      idle(3);

      // byte arriving exactly at expiry is accepted, no timeout
      send_byte(8'hC1); idle(GAP);
      send_byte(8'hC2);
      idle(T - 2);
      send_byte(8'hC3);
      check("expiry_race_no_tmo", timeout, 0);
      check("expiry_race_busy", busy, 1);
      for (int i = 0; i < 5; i++) begin
         idle(GAP);
         send_byte(8'hC4 + 8'(i));
      end
      check_frame("expiry_race", 16'hC1C2, 16'hC3C4, 32'hC5C6C7C8);
      idle(3);

      // byte in the same cycle as the transfer starts the next frame
      cmd_ready = 1'b0;
      send_frame(64'h0102A000DEADBEEF, GAP);
      check_frame("sameclk_a", 16'h0102, 16'hA000, 32'hDEADBEEF);
      idle(4);
      cmd_ready = 1'b1; rx_done = 1'b1; rx_data = 8'h77;
      @(posedge clk);
      #1 rx_done = 1'b0;
      check("sameclk_no_overrun", overrun, 0);
      check("sameclk_valid_low", cmd_valid, 0);
      check("sameclk_busy", busy, 1);
      check("sameclk_old_opcode", opcode, 16'h0102);
      for (int i = 0; i < 7; i++) begin
         idle(GAP);
         send_byte(8'h78 + 8'(i));
      end
      check_frame("sameclk_b", 16'h7778, 16'h797A, 32'h7B7C7D7E);
      idle(3);

      // reset mid-frame
      for (int i = 0; i < 5; i++) begin
         send_byte(8'h90 + 8'(i)); idle(GAP);
      end
      n_reset = 1'b0;
      idle(1);
      n_reset = 1'b1;
      check("midrst_valid", cmd_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_fields", {opcode, addr, data}, 64'd0);
      idle(2);
      send_frame(64'h2122232425262728, GAP);
      check_frame("after_midrst", 16'h2122, 16'h2324, 32'h25262728);
      idle(3);

      // back-to-back random frames, done high every cycle
      check("pre_stream_overruns", 64'(n_ovr), 64'd1);
      check("pre_stream_timeouts", 64'(n_tmo), 64'd1);
      stream_mon = 1'b1;
      for (int f = 0; f < 3; f++) begin
         logic [63:0] fr;
         fr = '0;
         for (int b = 0; b < 8; b++) begin
            rx_done = 1'b1;
            rx_data = 8'($urandom_range(0, 255));
            fr = {fr[55:0], rx_data};
            @(posedge clk);
            #1;
         end
         exp_q.push_back(fr);
      end
      rx_done = 1'b0;
      idle(5);
      stream_mon = 1'b0;
      check("stream_count", 64'(n_xfer), 64'd3);
      check("stream_queue_empty", 64'(exp_q.size()), 64'd0);
      check("stream_overruns", 64'(n_ovr), 64'd1);
      check("stream_timeouts", 64'(n_tmo), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_cmd_frame_assembler.md
Name: uart_cmd_frame_assembler

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream (received byte plus one-cycle done pulse).
- Packs OPC_BYTES + ADDR_BYTES + DATA_BYTES consecutive bytes into one command frame: opcode, memory address, data word.
- Presents each complete frame to the command decoder over a valid/ready handshake.
- Discards stalled partial frames via an inter-byte timeout and flags bytes lost while a frame is waiting.

Parameters:
- OPC_BYTES, 2, opcode field size in bytes.
- ADDR_BYTES, 2, address field size in bytes.
- DATA_BYTES, 4, data field size in bytes.
- TIMEOUT_CYCLES, 13020, clock cycles without a byte before a partial frame is dropped (3 byte-times at 50 MHz / 115200 baud).

Ports:
- i_clock  input  1  system clock, 50 MHz.
- i_n_reset  input  1  reset; synchronous and active-low.
- i_rx_done  input  1  one-cycle pulse from the UART receiver: i_rx_data is valid this cycle.
- i_rx_data  input  8  received byte.
- i_cmd_ready  input  1  consumer accepts the frame this cycle.
- o_cmd_valid  output  1  complete frame held on o_opcode/o_addr/o_data.
- o_opcode  output  8*OPC_BYTES  opcode field.
- o_addr  output  8*ADDR_BYTES  address field.
- o_data  output  8*DATA_BYTES  data field.
- o_busy  output  1  partial frame in progress (byte count 1..N-1).
- o_overrun  output  1  one-cycle pulse: byte dropped because a frame was pending.
- o_timeout  output  1  one-cycle pulse: partial frame discarded on timeout.

Behaviour:
- N = OPC_BYTES+ADDR_BYTES+DATA_BYTES (8 by default). The byte counter is $clog2(N+1) bits wide; the timeout counter is $clog2(TIMEOUT_CYCLES+1) bits wide.
- Reset (i_n_reset=0 at a rising edge): every output is 0, byte count 0, timeout counter 0, state COLLECT. Any partial or pending frame is lost. Reset wins over all other inputs.
- Byte order is big-endian in arrival order. Byte 0 is the opcode MSB. Bytes 0..OPC_BYTES-1 form the opcode, the next ADDR_BYTES form the address, and the remaining DATA_BYTES form the data, MSB first.
- State machine has two states: COLLECT and HOLD.
- COLLECT, on i_rx_done: the byte is stored in its slot and the count increments. If it was byte N-1, the next state is HOLD and o_cmd_valid=1 from the next cycle. Latency is 1 cycle from the final i_rx_done to valid.
- HOLD: o_cmd_valid=1 and all fields are stable until a transfer (o_cmd_valid && i_cmd_ready at a clock edge). After the transfer, o_cmd_valid=0 the next cycle and the state returns to COLLECT with count 0. Field outputs keep their last values; they carry no meaning while valid=0.
- HOLD with i_rx_done and no transfer this cycle: the byte is dropped and o_overrun pulses for 1 cycle. Held fields do not change.
- HOLD with i_rx_done in the same cycle as a transfer: the byte is accepted as byte 0 of the next frame (count becomes 1) and o_overrun stays 0. Held output fields still show the old frame on that edge; the new byte lives in internal storage until the next frame completes.
- Timeout:
  - Counts only in COLLECT with count 1..N-1. It clears to 0 on every accepted byte.
  - When it reaches TIMEOUT_CYCLES with no i_rx_done that cycle, count goes to 0, o_timeout pulses for 1 cycle and o_busy falls.
  - If i_rx_done coincides with expiry, the byte is accepted and no timeout occurs.
- Neither count 0 nor HOLD ever times out.
- o_busy=1 exactly when in COLLECT with count 1..N-1.
- i_cmd_ready has no effect while o_cmd_valid=0.

Test Plan:
- Reset, then bytes 01 02 A0 00 DE AD BE EF, 4340 cycles apart, with i_cmd_ready=1 -> o_cmd_valid high 1 cycle after the 8th done; opcode=0x0102, addr=0xA000, data=0xDEADBEEF; valid low next cycle.
- Same frame with i_cmd_ready=0 for 5000 cycles, and byte 0x55 arriving during the hold -> fields stable, one o_overrun pulse, then after ready=1 the next frame starts fresh with 0x55 discarded.
- 3 bytes then silence -> o_timeout pulses exactly TIMEOUT_CYCLES cycles after the 3rd byte and o_busy falls. The next 8 bytes 11..18 yield opcode=0x1112, addr=0x1314, data=0x15161718.
- i_rx_done=0x77 in the same cycle as the transfer of frame A -> no overrun; after 7 more bytes 0x78..0x7E the frame has opcode=0x7778, addr=0x797A, data=0x7B7C7D7E.
- i_n_reset=0 after 5 bytes for 1 cycle -> all outputs 0; the following 8 bytes form a complete, correct frame.
- Back-to-back frames from UartTransmit looped through UartRecieve, with 3 random frames and ready always 1 -> 3 valid pulses, fields match the sent bytes, no overrun or timeout.
